// File: rtl/ifm_window_streamer.sv
// ifm_window_streamer
//
// Producer for the KERNAL_SIZE x KERNAL_SIZE line-buffer window FIFO. Streams one
// IFM_SIZE x IFM_SIZE feature map out of a synchronous-read memory in row-major
// order, pushes each pixel into the window FIFO and flags the cycles in which the
// FIFO holds a complete, in-bounds window, tagged with its output coordinate.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, base_addr    begin a map at base_addr (sampled only while idle)
//   stall               back-pressure; suppresses new reads only
//   mem_rd_en, mem_addr memory read request (data returns one cycle later)
//   mem_rd_data         memory read data
//   fifo_enable         window FIFO shift strobe
//   fifo_data_in        pixel pushed into the window FIFO
//   window_valid        FIFO outputs form a complete window this cycle
//   out_row, out_col    output coordinate of that window
//   busy, done          map in progress / one-cycle completion pulse

module ifm_window_streamer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IFM_SIZE    = 28,
    parameter int unsigned KERNAL_SIZE = 5,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned CW          = $clog2(IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  fifo_enable,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  window_valid,
    output logic [CW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CW-1:0] KLast   = CW'(KERNAL_SIZE - 1);
    localparam logic [CW-1:0] PixLast = CW'(IFM_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_t;

    state_t                state_q;
    logic [CW-1:0]         r_q, c_q;          // next pixel to read
    logic [ADDR_WIDTH-1:0] addr_q;            // next read address, wraps naturally
    logic [CW-1:0]         rd_r_q, rd_c_q;    // coordinate of the read in flight
    logic [CW-1:0]         push_r_q, push_c_q; // coordinate of the pixel being pushed

    // The memory's output register already holds the pixel during the push
    // cycle; masking keeps the bus at zero whenever nothing is pushed,
    // including read data that was in flight across a reset.
    assign fifo_data_in = fifo_enable ? mem_rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            r_q          <= '0;
            c_q          <= '0;
            addr_q       <= '0;
            rd_r_q       <= '0;
            rd_c_q       <= '0;
            push_r_q     <= '0;
            push_c_q     <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            fifo_enable  <= 1'b0;
            window_valid <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Stage 1: push whatever was read last cycle, regardless of stall.
            fifo_enable <= mem_rd_en;
            push_r_q    <= rd_r_q;
            push_c_q    <= rd_c_q;

            // Stage 2: a window is complete once its bottom-right pixel is in.
            // Pixels with c < KERNAL_SIZE-1 would form a window wrapping rows.
            window_valid <= fifo_enable && (push_r_q >= KLast) && (push_c_q >= KLast);
            if (fifo_enable && (push_r_q >= KLast) && (push_c_q >= KLast)) begin
                out_row <= push_r_q - KLast;
                out_col <= push_c_q - KLast;
            end

            mem_rd_en <= 1'b0;
            done      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        r_q     <= '0;
                        c_q     <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    busy <= 1'b1;
                    if (!stall) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr_q;
                        addr_q    <= addr_q + 1'b1;
                        rd_r_q    <= r_q;
                        rd_c_q    <= c_q;
                        if (c_q == PixLast) begin
                            c_q <= '0;
                            if (r_q == PixLast) begin
                                state_q <= StDrain;
                            end else begin
                                r_q <= r_q + 1'b1;
                            end
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                end
                // Once the final read has returned, its push and window flag
                // are already committed to the pipeline; done follows the flag.
                StDrain: begin
                    if (!mem_rd_en) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_window_streamer.sv
// Self-checking bench for ifm_window_streamer. Stimulus code pushes the expected
// reads, pushes, windows and done pulses (with their cycle numbers) into queues;
// a monitor on the falling edge pops and compares whenever the DUT presents one.
// Cycle k is the period following rising edge k, counted by cyc.

module tb_ifm_window_streamer;

    localparam int DW    = 32;
    localparam int IFM   = 28;
    localparam int K     = 5;
    localparam int AW    = 16;
    localparam int CWID  = 5;
    localparam int NPIX  = IFM * IFM;
    localparam int NOCUT = 32'h7fff_ffff;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic            stall;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rd_data;
    logic            fifo_enable;
    logic [DW-1:0]   fifo_data_in;
    logic            window_valid;
    logic [CWID-1:0] out_row;
    logic [CWID-1:0] out_col;
    logic            busy;
    logic            done;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_win  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t rd_q[$];
    ev_t push_q[$];
    ev_t win_q[$];
    ev_t done_q[$];
    ev_t mon_ev;

    ifm_window_streamer #(
        .DATA_WIDTH (DW),
        .IFM_SIZE   (IFM),
        .KERNAL_SIZE(K),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .stall       (stall),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .fifo_enable (fifo_enable),
        .fifo_data_in(fifo_data_in),
        .window_valid(window_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory whose contents equal the address.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {16'h0000, mem_addr};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
    endtask

    // Expected events of one map. Stall is high in cycles s0..s0+slen-1, so reads
    // that would have issued at edges s0+1 onward slip by slen. Events after
    // cycle 'cut' are dropped (reset aborting the map).
    task automatic gen_map(input logic [15:0] base, input int e0, input int s0,
                           input int slen, input int cut);
        int k;
        ev_t ev;
        logic [15:0] a;
        k = 0;
        for (int p = 0; p < NPIX; p++) begin
            k = e0 + 1 + p;
            if (slen > 0 && k >= s0 + 1) k += slen;
            a = base + 16'(p);
            ev.b = '0;
            if (k <= cut) begin
                ev.cyc = k; ev.a = {16'h0000, a}; rd_q.push_back(ev);
            end
            if (k + 1 <= cut) begin
                ev.cyc = k + 1; ev.a = {16'h0000, a}; push_q.push_back(ev);
            end
            if ((p / IFM) >= K - 1 && (p % IFM) >= K - 1 && k + 2 <= cut) begin
                ev.cyc = k + 2;
                ev.a   = 32'((p / IFM) - (K - 1));
                ev.b   = 32'((p % IFM) - (K - 1));
                win_q.push_back(ev);
            end
        end
        if (k + 3 <= cut) begin
            ev.cyc = k + 3; ev.a = '0; ev.b = '0; done_q.push_back(ev);
        end
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rd_en"},    64'(mem_rd_en), 64'(0));
        chk({tag, "_mem_addr"},     64'(mem_addr), 64'(0));
        chk({tag, "_fifo_enable"},  64'(fifo_enable), 64'(0));
        chk({tag, "_fifo_data_in"}, 64'(fifo_data_in), 64'(0));
        chk({tag, "_window_valid"}, 64'(window_valid), 64'(0));
        chk({tag, "_out_row"},      64'(out_row), 64'(0));
        chk({tag, "_out_col"},      64'(out_col), 64'(0));
        chk({tag, "_busy"},         64'(busy), 64'(0));
        chk({tag, "_done"},         64'(done), 64'(0));
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (rd_q.size() == 0) unexpected("rd_unexpected");
            else begin
                mon_ev = rd_q.pop_front();
                chk("rd_addr", 64'(mem_addr), 64'(mon_ev.a));
                chk("rd_cycle", 64'(cyc), 64'(mon_ev.cyc));
            end
        end
        if (fifo_enable) begin
            n_push++;
            if (push_q.size() == 0) unexpected("push_unexpected");
            else begin
                mon_ev = push_q.pop_front();
                chk("push_data", 64'(fifo_data_in), 64'(mon_ev.a));
                chk("push_cycle", 64'(cyc), 64'(mon_ev.cyc));
            end
        end
        if (window_valid) begin
            n_win++;
            if (win_q.size() == 0) unexpected("win_unexpected");
            else begin
                mon_ev = win_q.pop_front();
                chk("win_row", 64'(out_row), 64'(mon_ev.a));
                chk("win_col", 64'(out_col), 64'(mon_ev.b));
                chk("win_cycle", 64'(cyc), 64'(mon_ev.cyc));
            end
        end
        if (done) begin
            if (done_q.size() == 0) unexpected("done_unexpected");
            else begin
                mon_ev = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_ev.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, np0, nw0;
        reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0;
        @(negedge clk);
        to_cycle(3);
        chk_all_zero("reset");
        reset = 1'b0;

        // Map at base 0, no stall.
        to_cycle(5);
        e = cyc + 1;
        gen_map(16'h0000, e, 0, 0, NOCUT);
        np0 = n_push; nw0 = n_win;
        base_addr = 16'h0000; start = 1'b1;
        to_cycle(e);
        start = 1'b0;
        chk("busy_c0", 64'(busy), 64'(0));
        to_cycle(e + 1);
        chk("busy_c1", 64'(busy), 64'(1));
        to_cycle(e + 118);
        chk("wv_c118", 64'(window_valid), 64'(0));
        to_cycle(e + 119);
        chk("wv_c119", 64'(window_valid), 64'(1));
        chk("row_c119", 64'(out_row), 64'(0));
        chk("col_c119", 64'(out_col), 64'(0));
        to_cycle(e + 146);  // pixel (5,3): row-wrap window
        chk("wv_wrap_5_3", 64'(window_valid), 64'(0));
        to_cycle(e + 147);  // pixel (5,4)
        chk("wv_5_4", 64'(window_valid), 64'(1));
        chk("row_5_4", 64'(out_row), 64'(1));
        chk("col_5_4", 64'(out_col), 64'(0));
        to_cycle(e + 786);
        chk("wv_c786", 64'(window_valid), 64'(1));
        chk("row_c786", 64'(out_row), 64'(23));
        chk("col_c786", 64'(out_col), 64'(23));
        chk("busy_c786", 64'(busy), 64'(1));
        to_cycle(e + 787);
        chk("done_c787", 64'(done), 64'(1));
        chk("busy_c787", 64'(busy), 64'(0));
        to_cycle(e + 788);
        chk("done_c788", 64'(done), 64'(0));
        chk("push_count", 64'(n_push - np0), 64'(784));
        chk("win_count", 64'(n_win - nw0), 64'(576));

        // Address wrap from 0xFFF0.
        to_cycle(e + 795);
        e = cyc + 1;
        gen_map(16'hFFF0, e, 0, 0, NOCUT);
        base_addr = 16'hFFF0; start = 1'b1;
        to_cycle(e);
        start = 1'b0;
        to_cycle(e + 16);
        chk("wrap_addr_ffff", 64'(mem_addr), 64'h0000_FFFF);
        to_cycle(e + 17);
        chk("wrap_addr_0000", 64'(mem_addr), 64'h0000_0000);
        chk("wrap_data_ffff", 64'(fifo_data_in), 64'h0000_FFFF);

        // Stall high in cycles 50..59.
        to_cycle(e + 795);
        e = cyc + 1;
        gen_map(16'h0200, e, e + 50, 10, NOCUT);
        base_addr = 16'h0200; start = 1'b1;
        to_cycle(e);
        start = 1'b0;
        to_cycle(e + 50);
        stall = 1'b1;
        to_cycle(e + 51);
        chk("stall_push49_en", 64'(fifo_enable), 64'(1));
        chk("stall_push49_data", 64'(fifo_data_in), 64'h0000_0231);
        for (int t = 51; t <= 60; t++) begin
            to_cycle(e + t);
            chk("stall_no_read", 64'(mem_rd_en), 64'(0));
        end
        stall = 1'b0;
        to_cycle(e + 797);
        chk("stall_done_c797", 64'(done), 64'(1));

        // Reset in cycle 300, restart at cycle 305.
        to_cycle(e + 800);
        e = cyc + 1;
        gen_map(16'h0100, e, 0, 0, e + 300);
        base_addr = 16'h0100; start = 1'b1;
        to_cycle(e);
        start = 1'b0;
        to_cycle(e + 300);
        reset = 1'b1;
        to_cycle(e + 301);
        reset = 1'b0;
        chk_all_zero("midreset");
        to_cycle(e + 305);
        e2 = e + 306;
        gen_map(16'h0100, e2, 0, 0, NOCUT);
        start = 1'b1;
        to_cycle(e2);
        start = 1'b0;
        to_cycle(e2 + 1);
        chk("restart_rd_en", 64'(mem_rd_en), 64'(1));
        chk("restart_addr", 64'(mem_addr), 64'h0000_0100);

        // Start held high: back-to-back maps.
        to_cycle(e2 + 795);
        e = cyc + 1;
        e2 = e + 788;
        gen_map(16'h0040, e, 0, 0, NOCUT);
        gen_map(16'h0040, e2, 0, 0, NOCUT);
        base_addr = 16'h0040; start = 1'b1;
        to_cycle(e + 400);
        chk("held_busy", 64'(busy), 64'(1));
        to_cycle(e + 787);
        chk("held_done1", 64'(done), 64'(1));
        to_cycle(e2 + 1);
        chk("held_map2_rd_en", 64'(mem_rd_en), 64'(1));
        chk("held_map2_addr", 64'(mem_addr), 64'h0000_0040);
        to_cycle(e2 + 787);
        chk("held_done2", 64'(done), 64'(1));
        start = 1'b0;
        to_cycle(e2 + 795);
        chk("held_idle_busy", 64'(busy), 64'(0));
        chk("held_idle_rd_en", 64'(mem_rd_en), 64'(0));

        chk("rd_q_left", 64'(rd_q.size()), 64'(0));
        chk("push_q_left", 64'(push_q.size()), 64'(0));
        chk("win_q_left", 64'(win_q.size()), 64'(0));
        chk("done_q_left", 64'(done_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
